pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor. Successor to the fixed 16-bit ripple-carry adder.
- Splits a WIDTH-bit operation into CHUNK-bit ripple slices, one pipeline stage per slice. Carries are registered between stages, giving one result per cycle.
- Valid/ready handshakes on input and output.
- Adds subtract mode, a signed-overflow flag and back-pressure, none of which the combinational 16-bit adder has.

---
 rtl/pipelined_addsub.sv | 116 +++++++++++
 tb/tb_pipelined_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits resolved CHUNK bits per stage,
// carries registered between stages, valid/ready on both sides, whole pipe stalls on back-pressure.
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] vld_q, c_q, c_d;
  logic [STAGES:0]   vld_pipe;
  logic              ovf_q;

  assign b_eff     = sub ? ~b : b;
  assign cin_eff   = sub ? ~cin : cin;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
    end else if (adv) begin
      vld_q <= vld_pipe[STAGES-1:0];
      c_q   <= c_d;
    end
  end

  // Stage k sees only the operand bits not yet consumed (bit 0 = slice k) and
  // accumulates the result slices resolved so far.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int OPW = WIDTH - k*CHUNK;
    logic [OPW-1:0]         a_src, b_src;
    logic                   c_in;
    logic [CHUNK-1:0]       s;
    logic [(k+1)*CHUNK-1:0] res_d, res_q;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign c_in  = cin_eff;
      assign res_d = s;
    end else begin : g_body
      assign a_src = stg[k-1].g_dly.a_q;
      assign b_src = stg[k-1].g_dly.b_q;
      assign c_in  = c_q[k-1];
      assign res_d = {s, stg[k-1].res_q};
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i (a_src[CHUNK-1:0]),
      .b_i (b_src[CHUNK-1:0]),
      .c_i (c_in),
      .s_o (s),
      .c_o (c_d[k])
    );

    always_ff @(posedge clk) begin
      if (rst)      res_q <= '0;
      else if (adv) res_q <= res_d;
    end

    if (k < STAGES-1) begin : g_dly
      logic [OPW-CHUNK-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[OPW-1:CHUNK];
          b_q <= b_src[OPW-1:CHUNK];
        end
      end
    end else begin : g_last
      // Operand MSBs arrive here with the top slice, so signed overflow is resolved in the last stage.
      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= (a_src[OPW-1] == b_src[OPW-1]) && (s[CHUNK-1] != a_src[OPW-1]);
      end
    end
  end

  assign sum  = stg[STAGES-1].res_q;
  assign cout = c_q[STAGES-1];
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: default 16/4 instance plus 32/8 and 8/8 sweep instances.
module tb_pipelined_addsub;
  localparam int STAGES = 4;

  logic clk, rst;
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic v32, rdy32, ov32, c32, ovf32;
  logic [31:0] a32, b32, s32;
  logic v8, rdy8, ov8, c8, ovf8;
  logic [7:0] a8, b8, s8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd = 0;
  bit lat_chk = 1;
  bit stalled = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;
  exp_t sb[$];

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
    .cin(1'b0), .sub(1'b0), .out_valid(ov32), .out_ready(1'b1),
    .sum(s32), .cout(c32), .ovf(ovf32));

  pipelined_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(1'b0), .sub(1'b0), .out_valid(ov8), .out_ready(1'b1),
    .sum(s8), .cout(c8), .ovf(ovf8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference built on wide unsigned and signed integer arithmetic: {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [16:0] r;
    int sr;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y} + 17'(c);
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
    end else begin
      r  = 17'h10000 + {1'b0, x} - {1'b0, y} - 17'(c);
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
    end
    return {(sr > 32767 || sr < -32768), r};
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                      input logic [15:0] es, input logic ec, input logic eo);
    int n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      step();
      n++;
      if (n > 100) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back('{sum: es, cout: ec, ovf: eo, acc: cyc});
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [17:0] r;
    ra = 16'($urandom); rb = 16'($urandom);
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    r = model(ra, rb, rc, rs);
    send(ra, rb, rc, rs, r[15:0], r[16], r[17]);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output-side scoreboard: data is compared on every valid cycle, so stalls also check holding.
  always @(negedge clk) begin
    exp_t e;
    if (rst) stalled = 1'b0;
    else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stalled) chk("hold_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious", 32'(out_valid), 32'd0);
        else begin
          e = sb[0];
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          if (out_ready) begin
            if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'(STAGES));
            void'(sb.pop_front());
          end
        end
      end
      stalled = out_valid && !out_ready;
    end
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; v8 = 1'b0; a8 = '0; b8 = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();

    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 16; i++) send_rand();
    drain();

    send_rand();
    step();
    send_rand();
    send_rand();
    drain();

    rnd = 1'b1; lat_chk = 1'b0;
    for (int i = 0; i < 40; i++) send_rand();
    drain();
    rnd = 1'b0; lat_chk = 1'b1; out_ready = 1'b1;
    step();

    // Three items in flight, none at the output yet when reset hits.
    send_rand();
    send_rand();
    send_rand();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    repeat (8) step();
    send(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    drain();

    v32 = 1'b1; a32 = 32'hDEADBEEF; b32 = 32'h21524111;
    @(negedge clk);
    chk("w32_in_ready", 32'(rdy32), 32'd1);
    step();
    v32 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!ov32 && k < 20) begin step(); k++; @(negedge clk); end
    chk("w32_latency", 32'(k + 1), 32'd4);
    chk("w32_sum", s32, 32'h00000000);
    chk("w32_cout", 32'(c32), 32'd1);
    chk("w32_ovf", 32'(ovf32), 32'd0);

    step();
    v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    chk("w8_in_ready", 32'(rdy8), 32'd1);
    step();
    v8 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!ov8 && k < 20) begin step(); k++; @(negedge clk); end
    chk("w8_latency", 32'(k + 1), 32'd1);
    chk("w8_sum", 32'(s8), 32'h80);
    chk("w8_cout", 32'(c8), 32'd0);
    chk("w8_ovf", 32'(ovf8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
